flappy_game_ctrl: RTL
=====================

Name: flappy_game_ctrl

Overview:
Top-level game sequencer for FlappyBird. It runs once per game tick on clk10 and owns the bird's vertical physics and the collision check against the three tubes. It also sequences the tube generator: holds it in clear, lets it run, or freezes it. It tracks the high score across rounds.

Parameters:
BIRD_X, 100, fixed bird left edge (px)
BIRD_SIZE, 16, bird square side (px)
BIRD_Y_INIT, 240, bird top edge at round start
SCREEN_H, 480, playfield height; floor at SCREEN_H-BIRD_SIZE
TUBE_W, 40, tube width (px)
GAP_H, 120, vertical gap height; tubeN_y_pos = gap top edge
GRAVITY, 1, velocity increment per tick
FLAP_V, 8, upward velocity magnitude applied on flap
VMAX, 10, max downward velocity
DEATH_TICKS, 20, ticks spent in DYING

Ports:
clk10  in  1  game tick clock
clr  in  1  synchronous active-high reset
btn_flap  in  1  flap button, level, already synchronised
tube1_x_pos  in  10  tube 1 left edge
tube2_x_pos  in  10  tube 2 left edge
tube3_x_pos  in  10  tube 3 left edge
tube1_y_pos  in  10  tube 1 gap top
tube2_y_pos  in  10  tube 2 gap top
tube3_y_pos  in  10  tube 3 gap top
score  in  8  current score from tube generator
tube_clr  out  1  drives tube generator clr
tube_run  out  1  tube generator advance enable
bird_y_pos  out  10  bird top edge
game_state  out  2  0 IDLE, 1 PLAY, 2 DYING, 3 OVER
collision  out  1  sticky hit flag for the current round
high_score  out  8  best score since reset

Behaviour:
- One clock domain, clk10. Reset is synchronous and active-high on clr; the polarity and synchronicity are fixed.
- Reset values: state IDLE, bird_y_pos=BIRD_Y_INIT, velocity=0, tube_clr=1, tube_run=0, collision=0, high_score=0, btn_prev=0.
- All outputs are registered.
- Flap event = btn_flap & ~btn_prev (rising edge). Holding the button gives exactly one flap.
- Velocity is an 8-bit signed value, negative meaning upward. The y update is computed in 11-bit signed.
- IDLE:
  - tube_clr=1, tube_run=0.
  - bird_y_pos held at BIRD_Y_INIT, collision=0.
  - On a flap: next state PLAY, vel<=-FLAP_V, y unchanged.
- PLAY:
  - tube_clr=0, tube_run=1.
  - Each tick: y<=y+vel.
  - vel<=-FLAP_V if flap, else min(vel+GRAVITY, VMAX).
  - Ceiling: if y+vel<0, then y<=0 and vel<=0; a flap on the same tick still sets vel to -FLAP_V.
  - Floor: if y+vel>=SCREEN_H-BIRD_SIZE, then y<=SCREEN_H-BIRD_SIZE and a hit is flagged.
- Tube hit test, per tube N, evaluated on the registered y and the current inputs:
  - x-overlap: (BIRD_X+BIRD_SIZE > xN) && (BIRD_X < xN+TUBE_W).
  - outside gap: (y < yN) || (y+BIRD_SIZE > yN+GAP_H).
  - Hit when both are true. Floor contact also counts as a hit.
- On a hit in PLAY:
  - collision<=1 and next state DYING, on that same edge.
  - Hit beats flap: a flap on the hit tick is ignored.
  - Ticks before the hit still run the normal physics.
- DYING:
  - tube_run=0 (tubes frozen), tube_clr=0.
  - Flaps ignored. vel keeps accumulating gravity up to VMAX.
  - y falls and clamps at the floor.
  - A 5-bit counter runs from 0; when it reaches DEATH_TICKS-1, next state OVER.
- DYING->OVER transition edge: high_score<=max(high_score, score).
- OVER:
  - tube_run=0; bird held.
  - On a flap: next state IDLE, where tube_clr reasserts, y<=BIRD_Y_INIT, vel<=0, collision<=0.
- clr mid-round: every register returns to its reset value on the next edge, including high_score.
- Widths: no wrap. All compares are done in 11-bit unsigned, so xN+TUBE_W near 1023 cannot overflow.

Test Plan:
1. Reset, then idle for 5 ticks -> state 0, tube_clr=1, tube_run=0, bird_y_pos=240, high_score=0.
2. All tubes at x=600; one flap pulse -> state 1 on the next edge. bird_y_pos across successive ticks: 240, 232, 225, 219, 214, 210. tube_run=1.
3. Keep btn_flap high for 10 ticks in PLAY -> only one flap is applied; y trajectory matches a single flap.
4. No flaps, tubes far away -> bird reaches the floor. bird_y_pos clamps at 464, collision=1, state 2. After 20 ticks state=3. high_score equals score (e.g. score=7 gives high_score=7).
5. Tube1 at x=90, y=300; bird at y=240 -> hit on the first PLAY tick (bird above the gap) and state 2. Then move tube1_y_pos to 230: the bird is in the gap and there is no hit. Also drive a flap on the hit tick -> state still goes to 2.
6. From OVER with high_score=7: flap -> IDLE with collision=0. Next round ends with score=3 -> high_score stays 7. Assert clr during DYING -> next edge gives state 0 and high_score=0.

Source files
------------

// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: button, tube-generator and status signals of the game sequencer.
interface flappy_game_ctrl_if;
   logic       btn_flap;
   logic [9:0] tube1_x_pos;
   logic [9:0] tube2_x_pos;
   logic [9:0] tube3_x_pos;
   logic [9:0] tube1_y_pos;
   logic [9:0] tube2_y_pos;
   logic [9:0] tube3_y_pos;
   logic [7:0] score;
   logic       tube_clr;
   logic       tube_run;
   logic [9:0] bird_y_pos;
   logic [1:0] game_state;
   logic       collision;
   logic [7:0] high_score;
   modport master (
      output btn_flap, tube1_x_pos, tube2_x_pos, tube3_x_pos,
             tube1_y_pos, tube2_y_pos, tube3_y_pos, score,
      input  tube_clr, tube_run, bird_y_pos, game_state, collision, high_score
   );
   modport slave (
      input  btn_flap, tube1_x_pos, tube2_x_pos, tube3_x_pos,
             tube1_y_pos, tube2_y_pos, tube3_y_pos, score,
      output tube_clr, tube_run, bird_y_pos, game_state, collision, high_score
   );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-tick bird physics, tube collision, tube-generator sequencing and high score.
module flappy_game_ctrl #(
   parameter int BIRD_X      = 100,
   parameter int BIRD_SIZE   = 16,
   parameter int BIRD_Y_INIT = 240,
   parameter int SCREEN_H    = 480,
   parameter int TUBE_W      = 40,
   parameter int GAP_H       = 120,
   parameter int GRAVITY     = 1,
   parameter int FLAP_V      = 8,
   parameter int VMAX        = 10,
   parameter int DEATH_TICKS = 20
) (
   input logic clk10,
   input logic clr,
   flappy_game_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DYING, S_OVER} state_t;

   localparam logic signed [10:0] L_FLOOR      = 11'(SCREEN_H - BIRD_SIZE);
   localparam logic signed [7:0]  L_FLAP       = 8'(-FLAP_V);
   localparam logic signed [7:0]  L_VMAX       = 8'(VMAX);
   localparam logic signed [7:0]  L_GRAV       = 8'(GRAVITY);
   localparam logic [9:0]         L_Y_INIT     = 10'(BIRD_Y_INIT);
   localparam logic [4:0]         L_DEATH_LAST = 5'(DEATH_TICKS - 1);

   state_t             r_state, w_state_nxt;
   logic [9:0]         r_y, w_y_nxt, w_y_phys;
   logic signed [7:0]  r_vel, w_vel_nxt, w_vel_inc, w_vel_phys;
   logic [4:0]         r_cnt, w_cnt_nxt;
   logic               r_coll, w_coll_nxt;
   logic [7:0]         r_hs, w_hs_nxt;
   logic               r_btn_prev;
   logic               r_tube_clr, w_tube_clr_nxt;
   logic               r_tube_run, w_tube_run_nxt;
   logic signed [10:0] w_sum;
   logic               w_flap, w_floor, w_hit;

   // All compares widened to 11 bits so x + TUBE_W and y + GAP_H never wrap.
   function automatic logic f_tube_hit(input logic [9:0] x, input logic [9:0] gy, input logic [9:0] by);
      logic [10:0] xe, ge, be;
      xe = {1'b0, x};
      ge = {1'b0, gy};
      be = {1'b0, by};
      return (11'(BIRD_X + BIRD_SIZE) > xe) && (11'(BIRD_X) < xe + 11'(TUBE_W)) &&
             ((be < ge) || (be + 11'(BIRD_SIZE) > ge + 11'(GAP_H)));
   endfunction

   assign w_flap     = bus.btn_flap & ~r_btn_prev;
   assign w_sum      = $signed({1'b0, r_y}) + $signed({{3{r_vel[7]}}, r_vel});
   assign w_floor    = w_sum >= L_FLOOR;
   assign w_vel_inc  = r_vel + L_GRAV;
   assign w_vel_phys = w_sum[10] ? 8'sd0 : (w_vel_inc > L_VMAX ? L_VMAX : w_vel_inc);
   assign w_y_phys   = w_sum[10] ? 10'd0 : (w_floor ? L_FLOOR[9:0] : w_sum[9:0]);
   assign w_hit      = w_floor |
                       f_tube_hit(bus.tube1_x_pos, bus.tube1_y_pos, r_y) |
                       f_tube_hit(bus.tube2_x_pos, bus.tube2_y_pos, r_y) |
                       f_tube_hit(bus.tube3_x_pos, bus.tube3_y_pos, r_y);

   always_ff @(posedge clk10) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_flap ? S_PLAY : S_IDLE;
         S_PLAY:  w_state_nxt = w_hit ? S_DYING : S_PLAY;
         S_DYING: w_state_nxt = (r_cnt == L_DEATH_LAST) ? S_OVER : S_DYING;
         default: w_state_nxt = w_flap ? S_IDLE : S_OVER;
      endcase
   end

   // A hit in PLAY masks any flap on the same tick.
   always_comb begin
      w_y_nxt    = r_y;
      w_vel_nxt  = r_vel;
      w_coll_nxt = r_coll;
      case (r_state)
         S_IDLE: begin
            w_y_nxt    = L_Y_INIT;
            w_vel_nxt  = w_flap ? L_FLAP : 8'sd0;
            w_coll_nxt = 1'b0;
         end
         S_PLAY: begin
            w_y_nxt    = w_y_phys;
            w_vel_nxt  = (w_flap && !w_hit) ? L_FLAP : w_vel_phys;
            w_coll_nxt = w_hit;
         end
         S_DYING: begin
            w_y_nxt    = w_y_phys;
            w_vel_nxt  = w_vel_phys;
            w_coll_nxt = 1'b1;
         end
         default: begin
            w_y_nxt    = w_flap ? L_Y_INIT : r_y;
            w_vel_nxt  = w_flap ? 8'sd0 : r_vel;
            w_coll_nxt = w_flap ? 1'b0 : r_coll;
         end
      endcase
      w_cnt_nxt      = (r_state == S_DYING) ? r_cnt + 5'd1 : 5'd0;
      w_hs_nxt       = (r_state == S_DYING && w_state_nxt == S_OVER && bus.score > r_hs) ? bus.score : r_hs;
      w_tube_clr_nxt = (w_state_nxt == S_IDLE);
      w_tube_run_nxt = (w_state_nxt == S_PLAY);
   end

   always_ff @(posedge clk10) begin
      if (clr) begin
         r_y        <= L_Y_INIT;
         r_vel      <= 8'sd0;
         r_cnt      <= 5'd0;
         r_coll     <= 1'b0;
         r_hs       <= 8'd0;
         r_btn_prev <= 1'b0;
         r_tube_clr <= 1'b1;
         r_tube_run <= 1'b0;
      end else begin
         r_y        <= w_y_nxt;
         r_vel      <= w_vel_nxt;
         r_cnt      <= w_cnt_nxt;
         r_coll     <= w_coll_nxt;
         r_hs       <= w_hs_nxt;
         r_btn_prev <= bus.btn_flap;
         r_tube_clr <= w_tube_clr_nxt;
         r_tube_run <= w_tube_run_nxt;
      end
   end

   assign bus.tube_clr   = r_tube_clr;
   assign bus.tube_run   = r_tube_run;
   assign bus.bird_y_pos = r_y;
   assign bus.game_state = r_state;
   assign bus.collision  = r_coll;
   assign bus.high_score = r_hs;
endmodule
